// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus valid/ready stream seen by the reader.
interface fifo_stream_reader_if #(parameter int DATA_WIDTH = 8);
  logic fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_r_data;
  logic fifo_rd_en;
  logic m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic m_ready;
  modport master (input fifo_empty, fifo_r_data, m_ready, output fifo_rd_en, m_valid, m_data);
  modport slave (output fifo_empty, fifo_r_data, m_ready, input fifo_rd_en, m_valid, m_data);
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: FIFO read engine feeding a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus,
  input  logic                 flush,
  input  logic                 count_clr,
  output logic [CNT_WIDTH-1:0] beat_count
);
  logic [1:0] occ;
  logic inflight;
  logic discard;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic pop;
  logic capture;
  assign pop = bus.m_valid && bus.m_ready;
  // a word landing in the flush cycle is dropped along with the buffer
  assign capture = inflight && !discard && !flush;
  // occ + inflight never exceeds 2, so the 2-bit sum cannot wrap
  assign bus.fifo_rd_en = rst_n && !bus.fifo_empty && !flush && ((occ + {1'b0, inflight}) < 2'd2 || pop);
  assign bus.m_valid = occ != 2'd0;
  assign bus.m_data = head;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      discard  <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= bus.fifo_rd_en;
      discard  <= flush && inflight;
      occ      <= flush ? 2'd0 : occ + {1'b0, capture} - {1'b0, pop};
      if (pop)
        head <= (occ == 2'd2) ? tail : bus.fifo_r_data;
      else if (capture && occ == 2'd0)
        head <= bus.fifo_r_data;
      if (capture && (occ == 2'd2 || (occ == 2'd1 && !pop)))
        tail <= bus.fifo_r_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beat_count <= '0;
    else if (count_clr)
      beat_count <= '0;
    else if (pop && !(&beat_count))
      beat_count <= beat_count + 1'b1;
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: table, directed and random checks against a write-order scoreboard.
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic count_clr = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [3:0] beat_count;
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  logic [7:0] exp_q[$];

  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .count_clr(count_clr), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle registered read, cleared by flush and reset
  logic [7:0] mem [256];
  logic [7:0] wp, rp;
  assign bus.fifo_empty = (wp == rp);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 8'd0;
      rp <= 8'd0;
      bus.fifo_r_data <= 8'd0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + 8'd1;
      end
      if (bus.fifo_rd_en && wp != rp) begin
        bus.fifo_r_data <= mem[rp];
        rp <= rp + 8'd1;
        rd_cnt <= rd_cnt + 1;
      end else if (flush) rp <= wp;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: delivered beats equal written words in order, minus anything flushed or reset
  initial begin
    int outst;
    int model_cnt;
    bit stall_prev;
    logic [7:0] prev_data;
    logic pop;
    outst = 0;
    model_cnt = 0;
    stall_prev = 0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        outst = 0;
        model_cnt = 0;
        stall_prev = 0;
      end else begin
        pop = bus.m_valid && bus.m_ready;
        if (stall_prev) begin
          chk("stall_valid", bus.m_valid, 1);
          chk("stall_data", bus.m_data, prev_data);
        end
        if (pop) begin
          chk("pop_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            chk("order", bus.m_data, exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
        chk("beat_count", beat_count, model_cnt);
        chk("rd_when_empty", bus.fifo_rd_en && bus.fifo_empty, 0);
        outst = flush ? 0 : outst + int'(bus.fifo_rd_en) - int'(pop);
        chk("outstanding_le2", outst <= 2, 1);
        model_cnt = count_clr ? 0 : (pop && model_cnt < 15) ? model_cnt + 1 : model_cnt;
        if (flush) exp_q.delete();
        if (wr_en) exp_q.push_back(wr_data);
        stall_prev = bus.m_valid && !bus.m_ready && !flush;
        prev_data = bus.m_data;
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    bus.m_ready = 1'b1;
    wr_en = 1'b0;
    while ((exp_q.size() != 0 || bus.m_valid) && n < 200) begin
      step();
      n++;
    end
    chk("drain_done", n < 200, 1);
    repeat (2) step();
  endtask

  typedef struct {
    logic wr;
    logic [7:0] d;
    logic rdy;
    logic ev;
    logic [7:0] ed;
    logic erd;
    logic [3:0] ec;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int k;
    int r0;
    logic [3:0] bc;
    tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0};
    tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b1, 4'd0};
    tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b1, 4'd0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1, 4'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 4'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0, 4'd2};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd3};
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_count", beat_count, 0);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      wr_en = tbl[i].wr;
      wr_data = tbl[i].d;
      bus.m_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), bus.m_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), bus.m_data, tbl[i].ed);
      chk($sformatf("tbl%0d_rd_en", i), bus.fifo_rd_en, tbl[i].erd);
      chk($sformatf("tbl%0d_count", i), beat_count, tbl[i].ec);
      step();
    end
    // toggling backpressure
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    for (int i = 0; i < 48; i++) begin
      wr_en = i < 8;
      wr_data = 8'h40 + 8'(i);
      bus.m_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_count", beat_count, 8);
    drain();
    // long stall: only two reads may be issued
    bus.m_ready = 1'b0;
    r0 = rd_cnt;
    for (int i = 0; i < 10; i++) begin
      wr_en = i < 4;
      wr_data = 8'h60 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("stall_reads", rd_cnt - r0, 2);
    chk("stall_valid_hold", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_bubble", bus.m_valid, 1);
      step();
    end
    @(negedge clk);
    chk("stall_drained", bus.m_valid, 0);
    step();
    drain();
    // flush with one word buffered and one in flight
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = 8'hA0 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    flush = 1'b1;
    bc = beat_count;
    step();
    flush = 1'b0;
    chk("flush_valid", bus.m_valid, 0);
    wr_en = 1'b1;
    wr_data = 8'hB0;
    bus.m_ready = 1'b1;
    step();
    wr_en = 1'b0;
    k = 2;
    while (!bus.m_valid && k < 20) begin
      step();
      k++;
    end
    chk("flush_next_data", bus.m_data, 8'hB0);
    chk("flush_latency", k >= 3 && k < 20, 1);
    chk("flush_count", beat_count, bc);
    drain();
    // saturation and clear-over-pop
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i * 7 + 1);
      step();
    end
    drain();
    chk("sat_count", beat_count, 4'hF);
    bus.m_ready = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    repeat (4) step();
    chk("clr_pop_valid", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    chk("clr_over_pop", beat_count, 0);
    drain();
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      flush = $urandom_range(99, 0) < 2;
      count_clr = $urandom_range(99, 0) < 3;
      bus.m_ready = $urandom_range(99, 0) < 70;
      wr_en = !flush && ($urandom_range(99, 0) < 50) && (8'(wp - rp) < 8'd100);
      wr_data = 8'($urandom);
      step();
    end
    flush = 1'b0;
    count_clr = 1'b0;
    drain();
    // async reset with two words buffered
    bus.m_ready = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h5A;
    step();
    wr_data = 8'hC3;
    step();
    wr_en = 1'b0;
    repeat (5) step();
    chk("pre_rst_valid", bus.m_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.m_valid, 0);
    chk("arst_data", bus.m_data, 0);
    chk("arst_count", beat_count, 0);
    chk("arst_rd_en", bus.fifo_rd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.m_ready = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    chk("post_rst_c1", bus.m_valid, 0);
    step();
    chk("post_rst_c2", bus.m_valid, 0);
    step();
    chk("post_rst_c3", bus.m_valid, 1);
    chk("post_rst_data", bus.m_data, 8'h77);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
